// File: rtl/pcap_dma_pkg.sv
// rtl/pcap_dma_pkg.sv - shared types and constants for the PCAP DMA writer
// Contents: FSM state enum, IRQ flag bit indices, AXI attribute constants,
// default burst length.
package pcap_dma_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    WAIT_DATA = 3'd2,
    AW        = 3'd3,
    W         = 3'd4,
    B         = 3'd5,
    IRQ       = 3'd6
  } state_t;

  localparam int FLAG_BLOCK_FULL = 0;
  localparam int FLAG_COMPLETED  = 1;
  localparam int FLAG_TIMEOUT    = 2;
  localparam int FLAG_ADDR_ERROR = 3;
  localparam int FLAG_FIFO_OVF   = 4;
  localparam int FLAG_AXI_ERROR  = 5;

  localparam logic [2:0] AXI_AWSIZE  = 3'b010;
  localparam logic [1:0] AXI_AWBURST = 2'b01;
  localparam logic [1:0] AXI_OKAY    = 2'b00;

  localparam int BURST_LEN_DEF = 16;

endpackage

// File: rtl/pcap_dma_fifo.sv
// rtl/pcap_dma_fifo.sv - first-word-fall-through sample FIFO with level output
// Ports: i_clk clock; i_clr synchronous clear; i_wr/i_wdata write side (dropped
// when full); i_rd pop (ignored when empty); o_rdata head word; o_level fill
// count; o_full/o_empty flags.
module pcap_dma_fifo #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_full  = (r_level == DEPTH);
  assign o_empty = (r_level == '0);
  assign w_do_wr = i_wr & ~o_full;
  assign w_do_rd = i_rd & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pcap_dma_writer.sv
// rtl/pcap_dma_writer.sv - drains PCAP samples into host buffers over AXI3 HP0
// Ports: clk_i/reset_i clock and sync reset; enable_i session arm level;
// pcap_dat_i/pcap_dat_valid_i sample stream; pcap_done_i end of capture;
// dma_reset_i session abort; dma_addr_i/dma_addr_wstb_i next buffer post;
// block_size_i buffer bytes; timeout_i idle flush cycles (0 = off);
// irq_o/irq_status_o interrupt pulse and {words, flags}; fifo_overflow_o
// sticky drop flag; m_axi_* AXI3 write address/data/response channels.
module pcap_dma_writer
  import pcap_dma_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int FIFO_AW   = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic [DW-1:0] pcap_dat_i,
  input  logic          pcap_dat_valid_i,
  input  logic          pcap_done_i,
  input  logic          dma_reset_i,
  input  logic [31:0]   dma_addr_i,
  input  logic          dma_addr_wstb_i,
  input  logic [31:0]   block_size_i,
  input  logic [31:0]   timeout_i,
  output logic          irq_o,
  output logic [31:0]   irq_status_o,
  output logic          fifo_overflow_o,
  output logic [31:0]   m_axi_awaddr,
  output logic [3:0]    m_axi_awlen,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [DW-1:0] m_axi_wdata,
  output logic          m_axi_wlast,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready
);

  localparam int LW = $clog2(BURST_LEN) + 1;
  localparam logic [LW-1:0]      LEN_BURST  = LW'(BURST_LEN);
  localparam logic [FIFO_AW:0]   LVL_BURST  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [29:0]        ROOM_BURST = 30'(BURST_LEN);

  state_t          r_state, w_state_nxt;
  logic [25:0]     r_cur_addr, r_next_addr;
  logic            r_next_valid, r_need_addr, r_enable_d;
  logic [29:0]     r_buf_count;
  logic [LW-1:0]   r_len, r_beat, w_len_nxt, w_flush_len;
  logic [7:0]      r_flags, w_flag_set, w_evt_flags;
  logic            r_done_seen, r_tmo_hit, r_overflow, r_irq;
  logic [31:0]     r_irq_status, r_tmo_cnt;

  logic            w_rst, w_enable_rise, w_fifo_wr, w_fifo_rd, w_ovf;
  logic            w_full, w_empty, w_flush, w_tmo_run;
  logic [FIFO_AW:0] w_level;
  logic [DW-1:0]   w_fifo_rdata;
  logic [29:0]     w_block_words, w_room, w_buf_sum;
  logic            w_unused;

  assign w_rst         = reset_i | dma_reset_i;
  assign w_enable_rise = enable_i & ~r_enable_d;
  // Samples are only accepted inside a session; the arming edge itself counts.
  assign w_fifo_wr     = pcap_dat_valid_i & enable_i & ((r_state != IDLE) | w_enable_rise);
  assign w_fifo_rd     = (r_state == W) & m_axi_wready;
  assign w_ovf         = w_fifo_wr & w_full;
  assign w_block_words = block_size_i[31:2];
  assign w_room        = w_block_words - r_buf_count;
  assign w_buf_sum     = r_buf_count + 30'(r_len);
  assign w_flush       = r_done_seen | r_tmo_hit;
  assign w_tmo_run     = (r_state == WAIT_DATA) & ((r_buf_count != '0) | ~w_empty) &
                         (timeout_i != '0) & ~r_tmo_hit;
  assign w_unused      = ^{block_size_i[1:0], dma_addr_i[5:0]};

  pcap_dma_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .i_clk   (clk_i),
    .i_clr   (w_rst),
    .i_wr    (w_fifo_wr),
    .i_wdata (pcap_dat_i),
    .i_rd    (w_fifo_rd),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Partial burst: whatever is buffered, capped by burst length and buffer room.
  always_comb begin
    w_flush_len = LEN_BURST;
    if (w_level < LVL_BURST) w_flush_len = w_level[LW-1:0];
    if (w_room < 30'(w_flush_len)) w_flush_len = w_room[LW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_flag_set  = '0;
    case (r_state)
      IDLE:      if (w_enable_rise) w_state_nxt = WAIT_ADDR;
      WAIT_ADDR: begin
        if (r_next_valid) begin
          w_state_nxt = WAIT_DATA;
        end else if (r_need_addr) begin
          w_flag_set[FLAG_ADDR_ERROR] = 1'b1;
          w_state_nxt = IRQ;
        end
      end
      WAIT_DATA: begin
        if ((w_level >= LVL_BURST) && (w_room >= ROOM_BURST)) begin
          w_len_nxt   = LEN_BURST;
          w_state_nxt = AW;
        end else if (w_flush && !w_empty) begin
          w_len_nxt   = w_flush_len;
          w_state_nxt = AW;
        end else if (w_flush) begin
          w_flag_set[FLAG_COMPLETED] = r_done_seen;
          w_flag_set[FLAG_TIMEOUT]   = r_tmo_hit;
          w_state_nxt = IRQ;
        end
      end
      AW:        if (m_axi_awready) w_state_nxt = W;
      W:         if (m_axi_wready && (r_beat == r_len - 1'b1)) w_state_nxt = B;
      B: begin
        if (m_axi_bvalid) begin
          w_flag_set[FLAG_AXI_ERROR] = (m_axi_bresp != AXI_OKAY);
          if (w_buf_sum == w_block_words) begin
            w_flag_set[FLAG_BLOCK_FULL] = 1'b1;
            w_flag_set[FLAG_COMPLETED]  = r_done_seen & w_empty;
            w_state_nxt = IRQ;
          end else begin
            w_state_nxt = WAIT_DATA;
          end
        end
      end
      IRQ: begin
        if (r_flags[FLAG_COMPLETED] || r_flags[FLAG_ADDR_ERROR]) w_state_nxt = IDLE;
        else w_state_nxt = WAIT_ADDR;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_evt_flags = w_flag_set;
    w_evt_flags[FLAG_FIFO_OVF] = w_flag_set[FLAG_FIFO_OVF] | w_ovf;
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state      <= IDLE;
      r_cur_addr   <= '0;
      r_next_addr  <= '0;
      r_next_valid <= 1'b0;
      r_need_addr  <= 1'b0;
      r_enable_d   <= 1'b0;
      r_buf_count  <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_flags      <= '0;
      r_done_seen  <= 1'b0;
      r_tmo_hit    <= 1'b0;
      r_tmo_cnt    <= '0;
      r_overflow   <= 1'b0;
      r_irq        <= 1'b0;
      r_irq_status <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_enable_d <= enable_i;
      r_irq      <= (r_state == IRQ);

      if (r_state == WAIT_ADDR && r_next_valid) begin
        r_cur_addr   <= r_next_addr;
        r_next_valid <= 1'b0;
        r_buf_count  <= '0;
        r_need_addr  <= 1'b0;
      end
      // A strobe in the same cycle as a load keeps the freshly posted address.
      if (dma_addr_wstb_i) begin
        r_next_addr  <= dma_addr_i[31:6];
        r_next_valid <= 1'b1;
      end

      if (r_state == IDLE && w_enable_rise) r_done_seen <= 1'b0;
      if (pcap_done_i) r_done_seen <= 1'b1;

      if (w_ovf) r_overflow <= 1'b1;

      if (r_state == AW) r_beat <= '0;
      if (w_fifo_rd) r_beat <= r_beat + 1'b1;
      if (r_state == B && m_axi_bvalid) r_buf_count <= w_buf_sum;

      if (pcap_dat_valid_i || !w_tmo_run) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt + 32'd1 >= timeout_i) begin
        r_tmo_cnt <= '0;
        r_tmo_hit <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end

      if (r_state == IRQ) begin
        r_irq_status <= {r_buf_count[23:0], r_flags};
        r_flags      <= w_evt_flags;
        r_buf_count  <= '0;
        r_tmo_hit    <= 1'b0;
        r_need_addr  <= (w_state_nxt == WAIT_ADDR) & r_flags[FLAG_BLOCK_FULL];
      end else begin
        r_flags <= r_flags | w_evt_flags;
      end
    end
  end

  assign irq_o           = r_irq;
  assign irq_status_o    = r_irq_status;
  assign fifo_overflow_o = r_overflow;
  assign m_axi_awvalid   = (r_state == AW);
  assign m_axi_awaddr    = m_axi_awvalid ? ({r_cur_addr, 6'd0} + {r_buf_count, 2'b00}) : '0;
  assign m_axi_awlen     = m_axi_awvalid ? 4'(r_len - 1'b1) : '0;
  assign m_axi_wvalid    = (r_state == W);
  assign m_axi_wdata     = m_axi_wvalid ? w_fifo_rdata : '0;
  assign m_axi_wlast     = m_axi_wvalid & (r_beat == r_len - 1'b1);
  assign m_axi_bready    = (r_state == B);

endmodule

// File: tb/tb_pcap_dma_writer.sv
// tb/tb_pcap_dma_writer.sv - scoreboard bench for pcap_dma_writer
module tb_pcap_dma_writer;
  import pcap_dma_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1, enable_i = 1'b0, pcap_dat_valid_i = 1'b0;
  logic        pcap_done_i = 1'b0, dma_reset_i = 1'b0, dma_addr_wstb_i = 1'b0;
  logic [31:0] pcap_dat_i = '0, dma_addr_i = '0, block_size_i = 32'd256, timeout_i = '0;
  logic        irq_o, fifo_overflow_o;
  logic [31:0] irq_status_o, m_axi_awaddr, m_axi_wdata;
  logic [3:0]  m_axi_awlen;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b1, m_axi_wready = 1'b1, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;

  pcap_dma_writer dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .pcap_dat_i(pcap_dat_i), .pcap_dat_valid_i(pcap_dat_valid_i),
    .pcap_done_i(pcap_done_i), .dma_reset_i(dma_reset_i),
    .dma_addr_i(dma_addr_i), .dma_addr_wstb_i(dma_addr_wstb_i),
    .block_size_i(block_size_i), .timeout_i(timeout_i),
    .irq_o(irq_o), .irq_status_o(irq_status_o), .fifo_overflow_o(fifo_overflow_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_tests = 0, n_fail = 0;
  int n_aw_seen = 0;
  int b_total = 0, err_at = -1;
  logic [35:0] sb_aw[$];
  logic [31:0] sb_irq[$];
  logic [31:0] sb_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  initial forever begin
    logic [35:0] e;
    @(negedge clk);
    if (m_axi_awvalid && m_axi_awready) begin
      n_aw_seen++;
      if (sb_aw.size() == 0) check("unexpected_aw", m_axi_awaddr, 32'hFFFF_FFFF);
      else begin
        e = sb_aw.pop_front();
        check("awaddr", m_axi_awaddr, e[31:0]);
        check("awlen", {28'd0, m_axi_awlen}, {28'd0, e[35:32]});
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (sb_data.size() == 0) check("unexpected_wbeat", m_axi_wdata, 32'hFFFF_FFFF);
      else check("wdata", m_axi_wdata, sb_data.pop_front());
    end
    if (irq_o) begin
      if (sb_irq.size() == 0) check("unexpected_irq", irq_status_o, 32'hFFFF_FFFF);
      else check("irq_status", irq_status_o, sb_irq.pop_front());
    end
  end

  // Write-response slave: one B per completed burst, error on burst index err_at.
  initial forever begin
    logic b_hs, wl_hs;
    @(negedge clk);
    b_hs  = m_axi_bvalid && m_axi_bready;
    wl_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
    @(posedge clk); #1;
    if (b_hs) m_axi_bvalid = 1'b0;
    if (wl_hs) begin
      m_axi_bresp  = (b_total == err_at) ? 2'b10 : 2'b00;
      m_axi_bvalid = 1'b1;
      b_total++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic session(input logic [31:0] addr, input logic [31:0] bsize, input logic [31:0] tmo);
    enable_i = 1'b0;
    dma_reset_i = 1'b1; tick(1); dma_reset_i = 1'b0;
    sb_aw.delete(); sb_irq.delete(); sb_data.delete();
    block_size_i = bsize; timeout_i = tmo;
    dma_addr_i = addr; dma_addr_wstb_i = 1'b1; tick(1); dma_addr_wstb_i = 1'b0;
    enable_i = 1'b1; tick(2);
  endtask

  task automatic expect_bursts(input logic [31:0] addr, input int n, input logic [3:0] len);
    for (int i = 0; i < n; i++) sb_aw.push_back({len, addr + 32'(64 * i)});
  endtask

  task automatic push_words(input int n, input logic [31:0] base, input bit expected);
    for (int i = 0; i < n; i++) begin
      pcap_dat_i = base + 32'(i); pcap_dat_valid_i = 1'b1;
      if (expected) sb_data.push_back(pcap_dat_i);
      tick(1);
    end
    pcap_dat_valid_i = 1'b0;
  endtask

  task automatic done_pulse();
    pcap_done_i = 1'b1; tick(1); pcap_done_i = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c = 0;
    while ((sb_aw.size() + sb_irq.size() + sb_data.size()) != 0 && c < max_cyc) begin
      tick(1); c++;
    end
    tick(3);
    check(name, 32'(sb_aw.size() + sb_irq.size() + sb_data.size()), 32'd0);
  endtask

  initial begin
    int seen;
    tick(3);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_status", irq_status_o, 32'd0);
    check("rst_ovf", {31'd0, fifo_overflow_o}, 32'd0);
    check("rst_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
    reset_i = 1'b0; tick(2);

    // 64 words into a 256 B buffer, then done: four full bursts and one IRQ.
    session(32'h1000_0000, 32'd256, 32'd0);
    expect_bursts(32'h1000_0000, 4, 4'd15);
    sb_irq.push_back(32'h0000_4003);
    push_words(64, 32'hA000_0000, 1'b1);
    done_pulse();
    wait_drain("drain_t1", 2000);

    // Two buffers of 128 B, 40 words.
    session(32'h2000_0000, 32'd128, 32'd0);
    dma_addr_i = 32'h3000_0000; dma_addr_wstb_i = 1'b1; tick(1); dma_addr_wstb_i = 1'b0;
    expect_bursts(32'h2000_0000, 2, 4'd15);
    expect_bursts(32'h3000_0000, 1, 4'd7);
    sb_irq.push_back(32'h0000_2001);
    sb_irq.push_back(32'h0000_0802);
    push_words(40, 32'hB000_0000, 1'b1);
    done_pulse();
    wait_drain("drain_t2", 2000);

    // Idle timeout flushes a partial burst.
    session(32'h4000_0000, 32'd256, 32'd100);
    expect_bursts(32'h4000_0000, 1, 4'd4);
    sb_irq.push_back(32'h0000_0504);
    push_words(5, 32'hC000_0000, 1'b1);
    wait_drain("drain_t3", 400);

    // Block full with no next address: ADDR_ERROR, back to IDLE.
    session(32'h6000_0000, 32'd64, 32'd0);
    expect_bursts(32'h6000_0000, 1, 4'd15);
    sb_irq.push_back(32'h0000_1001);
    sb_irq.push_back(32'h0000_0008);
    push_words(16, 32'hD000_0000, 1'b1);
    wait_drain("drain_t4", 400);
    seen = n_aw_seen;
    push_words(20, 32'hD100_0000, 1'b0);
    tick(60);
    check("idle_no_aw", 32'(n_aw_seen), 32'(seen));
    check("fsm_idle", 32'(dut.r_state), 32'(IDLE));

    // FIFO overflow while W is stalled.
    session(32'h7000_0000, 32'd4096, 32'd0);
    m_axi_wready = 1'b0;
    expect_bursts(32'h7000_0000, 64, 4'd15);
    sb_irq.push_back(32'h0004_0013);
    push_words(1024, 32'hE000_0000, 1'b1);
    check("ovf_before", {31'd0, fifo_overflow_o}, 32'd0);
    push_words(1, 32'hEEEE_EEEE, 1'b0);
    tick(1);
    check("ovf_after", {31'd0, fifo_overflow_o}, 32'd1);
    done_pulse();
    m_axi_wready = 1'b1;
    wait_drain("drain_t5", 3000);

    // SLVERR on the first burst.
    session(32'h8000_0000, 32'd256, 32'd0);
    err_at = b_total;
    expect_bursts(32'h8000_0000, 2, 4'd15);
    sb_irq.push_back(32'h0000_2022);
    push_words(32, 32'hF000_0000, 1'b1);
    done_pulse();
    wait_drain("drain_t6", 1000);

    // dma_reset_i in the middle of a W burst.
    session(32'h9000_0000, 32'd256, 32'd0);
    check("status_cleared", irq_status_o, 32'd0);
    m_axi_wready = 1'b0;
    expect_bursts(32'h9000_0000, 1, 4'd15);
    push_words(16, 32'h9900_0000, 1'b1);
    begin
      int c = 0;
      while (!m_axi_wvalid && c < 100) begin tick(1); c++; end
    end
    check("reach_w", {31'd0, m_axi_wvalid}, 32'd1);
    dma_reset_i = 1'b1; tick(1); dma_reset_i = 1'b0;
    check("abort_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
    check("abort_aw_consumed", 32'(sb_aw.size()), 32'd0);
    sb_data.delete();
    m_axi_wready = 1'b1;
    enable_i = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
